// File: rtl/timer_irq_dev.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers.
// Drives the CPU external interrupt line as CTRL.IM & irq_flag.
module timer_irq_dev #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [CNT_W-1:0] din,
  output logic [CNT_W-1:0] dout,
  output logic             irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flag_q, flag_d;

  // State and register file update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= {CNT_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  // Next-state logic: FSM first, then bus writes override CTRL/flag
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    case (state_q)
      S_IDLE: begin
        if (ctrl_q[0]) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = S_IDLE;
        end else if (count_q > CNT_W'(1)) begin
          count_d = count_q - CNT_W'(1);
        end else begin
          count_d = {CNT_W{1'b0}};
          flag_d  = 1'b1;
          state_d = S_INT;
        end
      end
      S_INT: begin
        // Only MODE 01 auto-reloads; 10/11 fall back to one-shot
        if (ctrl_q[2:1] == 2'b01) begin
          flag_d = 1'b0;
        end else begin
          ctrl_d[0] = 1'b0;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (we) begin
      case (addr)
        2'd0: begin
          ctrl_d = din[3:0];
          flag_d = 1'b0;
        end
        2'd1: begin
          preset_d = din;
          flag_d   = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Combinational read mux
  always_comb begin
    case (addr)
      2'd0:    dout = {{(CNT_W-4){1'b0}}, ctrl_q};
      2'd1:    dout = preset_q;
      2'd2:    dout = count_q;
      default: dout = {CNT_W{1'b0}};
    endcase
  end

  assign irq = ctrl_q[3] & flag_q;

endmodule

// File: tb/tb_timer_irq_dev.sv
// Self-checking bench for timer_irq_dev: directed vector table, hand-written
// timing sequences, and randomized traffic against a cycle-age reference model.
module tb_timer_irq_dev;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  timer_irq_dev dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [1:0]  a;
    logic [31:0] d;
    logic [1:0]  ra;
    logic [31:0] exp_d;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic w, logic [1:0] a, logic [31:0] d,
                              logic [1:0] ra, logic [31:0] exp_d, logic exp_irq);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.ra = ra; v.exp_d = exp_d; v.exp_irq = exp_irq;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; we = 1'b0; addr = 2'd0; din = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Drive one bus cycle across a single rising edge; returns 1ns after it
  task automatic cyc(input logic w, input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    we = w; addr = a; din = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    addr = a;
    #1;
    check(name, dout, exp);
  endtask

  // Reference model: timer described by the number of edges since it left IDLE
  logic [3:0]  m_ctrl;
  logic [31:0] m_preset, m_count, m_loaded;
  logic        m_flag;
  int          m_age;
  int          m_len;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_step(input logic w, input logic [1:0] a, input logic [31:0] d);
    logic [3:0]  n_ctrl   = m_ctrl;
    logic [31:0] n_preset = m_preset;
    logic [31:0] n_count  = m_count;
    logic [31:0] n_loaded = m_loaded;
    logic        n_flag   = m_flag;
    int          n_age    = m_age;
    int          n_len    = m_len;
    if (m_age < 0) begin
      if (m_ctrl[0]) n_age = 0;
    end else if (m_age == 0) begin
      n_count  = m_preset;
      n_loaded = m_preset;
      n_len    = (m_preset == 32'd0) ? 1 : int'(m_preset);
      n_age    = 1;
    end else if (m_age <= m_len) begin
      if (!m_ctrl[0]) begin
        n_age = -1;
      end else if (m_age < m_len) begin
        n_count = m_loaded - 32'(m_age);
        n_age   = m_age + 1;
      end else begin
        n_count = 32'd0;
        n_flag  = 1'b1;
        n_age   = m_age + 1;
      end
    end else begin
      if (m_ctrl[2:1] == 2'b01) n_flag = 1'b0;
      else n_ctrl[0] = 1'b0;
      n_age = -1;
    end
    if (w && a == 2'd0) begin
      n_ctrl = d[3:0];
      n_flag = 1'b0;
    end
    if (w && a == 2'd1) begin
      n_preset = d;
      n_flag   = 1'b0;
    end
    m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count; m_loaded = n_loaded;
    m_flag = n_flag; m_age = n_age; m_len = n_len;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    for (int a = 0; a < 4; a++) rd(2'(a), 32'd0, "reset_reg");
    check("reset_irq", {31'd0, irq}, 32'd0);

    // One-shot PRESET=5 walk, then masked-irq case with PRESET=3
    tbl.push_back(mk(1'b1, 2'd1, 32'd5,  2'd1, 32'd5, 1'b0));
    tbl.push_back(mk(1'b1, 2'd0, 32'h9,  2'd0, 32'h9, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, 32'd0,  2'd2, 32'd0, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, 32'd0,  2'd2, 32'd5, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, 32'd0,  2'd2, 32'd4, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, 32'd0,  2'd2, 32'd3, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, 32'd0,  2'd2, 32'd2, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, 32'd0,  2'd2, 32'd1, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, 32'd0,  2'd2, 32'd0, 1'b1));
    tbl.push_back(mk(1'b0, 2'd0, 32'd0,  2'd0, 32'h8, 1'b1));
    tbl.push_back(mk(1'b0, 2'd0, 32'd0,  2'd0, 32'h8, 1'b1));
    tbl.push_back(mk(1'b1, 2'd0, 32'd0,  2'd0, 32'h0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd2, 32'h1234, 2'd2, 32'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd3, 32'hFFFF, 2'd3, 32'd0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd0, 32'hFFFFFFF0, 2'd0, 32'h0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd1, 32'd3,  2'd1, 32'd3, 1'b0));
    tbl.push_back(mk(1'b1, 2'd0, 32'h1,  2'd0, 32'h1, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, 32'd0,  2'd2, 32'd0, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, 32'd0,  2'd2, 32'd3, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, 32'd0,  2'd2, 32'd2, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, 32'd0,  2'd2, 32'd1, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, 32'd0,  2'd2, 32'd0, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, 32'd0,  2'd0, 32'h0, 1'b0));
    tbl.push_back(mk(1'b1, 2'd0, 32'h8,  2'd0, 32'h8, 1'b0));
    tbl.push_back(mk(1'b0, 2'd0, 32'd0,  2'd0, 32'h8, 1'b0));
    foreach (tbl[i]) begin
      cyc(tbl[i].w, tbl[i].a, tbl[i].d);
      rd(tbl[i].ra, tbl[i].exp_d, $sformatf("vec%0d_dout", i));
      check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].exp_irq});
    end

    // Auto-reload PRESET=2: 1-cycle pulse every 5 cycles
    do_reset();
    cyc(1'b1, 2'd1, 32'd2);
    cyc(1'b1, 2'd0, 32'hB);
    for (int off = 1; off <= 20; off++) begin
      @(posedge clk); #1;
      check($sformatf("reload_irq_off%0d", off), {31'd0, irq},
            {31'd0, (off >= 4 && (off - 4) % 5 == 0)});
    end

    // PRESET 0 and 1 share the same interrupt latency
    for (int p = 0; p < 2; p++) begin
      int seen;
      do_reset();
      cyc(1'b1, 2'd1, 32'(p));
      cyc(1'b1, 2'd0, 32'h9);
      seen = -1;
      for (int off = 1; off <= 20; off++) begin
        @(posedge clk); #1;
        if (irq && seen < 0) seen = off;
      end
      check($sformatf("latency_preset%0d", p), 32'(seen), 32'd3);
    end

    // Disable mid-count holds COUNT; re-enable reloads
    do_reset();
    cyc(1'b1, 2'd1, 32'd6);
    cyc(1'b1, 2'd0, 32'h9);
    repeat (4) @(posedge clk);
    cyc(1'b1, 2'd0, 32'h0);
    rd(2'd2, 32'd3, "hold_first");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      rd(2'd2, 32'd3, "hold_count");
    end
    cyc(1'b1, 2'd0, 32'h9);
    @(posedge clk); #1;
    rd(2'd2, 32'd3, "reenable_load");
    @(posedge clk); #1;
    rd(2'd2, 32'd6, "reenable_count");

    // Asynchronous reset with irq high, then mid-count
    do_reset();
    cyc(1'b1, 2'd1, 32'd1);
    cyc(1'b1, 2'd0, 32'h9);
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_irq", {31'd0, irq}, 32'd1);
    #1 reset = 1'b0;
    #1 check("async_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 3; a++) rd(2'(a), 32'd0, "async_reg");
    @(negedge clk); reset = 1'b1;
    cyc(1'b1, 2'd1, 32'd20);
    cyc(1'b1, 2'd0, 32'h9);
    repeat (5) @(posedge clk);
    addr = 2'd2;
    #1;
    check("midcnt_before", dout, 32'd17);
    #1 reset = 1'b0;
    #1 check("midcnt_async_count", dout, 32'd0);
    rd(2'd1, 32'd0, "midcnt_async_preset");

    // Randomized traffic against the reference model
    do_reset();
    m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_loaded = 32'd0;
    m_flag = 1'b0; m_age = -1; m_len = 1;
    for (int n = 0; n < 3000; n++) begin
      logic        w;
      logic [1:0]  a;
      logic [31:0] d;
      @(negedge clk);
      a = 2'($urandom_range(0, 3));
      w = ($urandom_range(0, 99) < 20);
      d = (a == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
      we = w; addr = a; din = d;
      #1;
      check("rand_dout", dout, m_read(a));
      check("rand_irq", {31'd0, irq}, {31'd0, m_ctrl[3] & m_flag});
      m_step(w, a, d);
    end
    we = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
